key_press_gen: RTL



---
 rtl/key_press_gen.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/key_press_gen.sv
// key_press_gen: key-press emulator driving an active-low key line (idle high).
// One press = press bounce, stable low hold, release bounce, stable-high settle.
// Optional feature macro: KEY_GEN_REPEAT_EN adds repeat_num and runs
// repeat_num+1 back-to-back presses per start.
// Outputs are registered decodes of the FSM state, so they trail the state by
// one cycle: a start sampled at edge E first moves key_out/busy at edge E+1.
module key_press_gen #(
  parameter int BOUNCE_LEN    = 4,
  parameter int HOLD_W        = 24,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic [3:0]        bounce_num,
`ifdef KEY_GEN_REPEAT_EN
  input  logic [3:0]        repeat_num,
`endif
  output logic              key_out,
  output logic              busy,
  output logic              done,
  output logic [7:0]        press_cnt
);

  localparam int BW   = $clog2(BOUNCE_LEN);
  localparam int SW   = $clog2(SETTLE_CYCLES);
  localparam int CW_A = (HOLD_W > BW) ? HOLD_W : BW;
  localparam int CW   = (CW_A > SW) ? CW_A : SW;
  localparam logic [CW-1:0] BOUNCE_LOAD = CW'(BOUNCE_LEN - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PB     = 3'd1,
    S_HOLD   = 3'd2,
    S_RB     = 3'd3,
    S_SETTLE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [3:0]        gcnt, gcnt_nxt;
  logic              half, half_nxt;
  logic [3:0]        bnum, bnum_nxt;
  logic [HOLD_W-1:0] hold_lat, hold_nxt;
`ifdef KEY_GEN_REPEAT_EN
  logic [3:0]        rep_cnt, rep_nxt;
`endif
  logic              key_s;
  logic              settle_last_s;
  logic              press_inc_s;

  // Hold length minus one for the down-counter; zero is treated as one cycle.
  function automatic logic [CW-1:0] hold_load(input logic [HOLD_W-1:0] h);
    if (h == {HOLD_W{1'b0}}) begin
      return {CW{1'b0}};
    end else begin
      return CW'(h - {{(HOLD_W-1){1'b0}}, 1'b1});
    end
  endfunction

  // FSM state and phase/glitch counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= {CW{1'b0}};
      gcnt     <= 4'd0;
      half     <= 1'b0;
      bnum     <= 4'd0;
      hold_lat <= {HOLD_W{1'b0}};
`ifdef KEY_GEN_REPEAT_EN
      rep_cnt  <= 4'd0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      gcnt     <= gcnt_nxt;
      half     <= half_nxt;
      bnum     <= bnum_nxt;
      hold_lat <= hold_nxt;
`ifdef KEY_GEN_REPEAT_EN
      rep_cnt  <= rep_nxt;
`endif
    end
  end

  // Next-state logic: each phase reloads the phase counter on entry and exits when it hits zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    half_nxt  = half;
    bnum_nxt  = bnum;
    hold_nxt  = hold_lat;
`ifdef KEY_GEN_REPEAT_EN
    rep_nxt   = rep_cnt;
`endif
    case (state)
      S_IDLE: begin
        // done is high in the first IDLE cycle; a start there is dropped
        if (start && !done) begin
          bnum_nxt = bounce_num;
          hold_nxt = hold_cycles;
`ifdef KEY_GEN_REPEAT_EN
          rep_nxt  = repeat_num;
`endif
          if (bounce_num == 4'd0) begin
            state_nxt = S_HOLD;
            cnt_nxt   = hold_load(hold_cycles);
          end else begin
            state_nxt = S_PB;
            cnt_nxt   = BOUNCE_LOAD;
            half_nxt  = 1'b0;
            gcnt_nxt  = bounce_num;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_PB, S_RB: begin
        if (cnt != {CW{1'b0}}) begin
          cnt_nxt = cnt - {{(CW-1){1'b0}}, 1'b1};
        end else if (!half) begin
          half_nxt = 1'b1;
          cnt_nxt  = BOUNCE_LOAD;
        end else if (gcnt == 4'd1) begin
          if (state == S_PB) begin
            state_nxt = S_HOLD;
            cnt_nxt   = hold_load(hold_lat);
          end else begin
            state_nxt = S_SETTLE;
            cnt_nxt   = SETTLE_LOAD;
          end
        end else begin
          gcnt_nxt = gcnt - 4'd1;
          half_nxt = 1'b0;
          cnt_nxt  = BOUNCE_LOAD;
        end
      end
      S_HOLD: begin
        if (cnt != {CW{1'b0}}) begin
          cnt_nxt = cnt - {{(CW-1){1'b0}}, 1'b1};
        end else if (bnum == 4'd0) begin
          state_nxt = S_SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end else begin
          state_nxt = S_RB;
          cnt_nxt   = BOUNCE_LOAD;
          half_nxt  = 1'b0;
          gcnt_nxt  = bnum;
        end
      end
      S_SETTLE: begin
        if (cnt != {CW{1'b0}}) begin
          cnt_nxt = cnt - {{(CW-1){1'b0}}, 1'b1};
`ifdef KEY_GEN_REPEAT_EN
        end else if (rep_cnt != 4'd0) begin
          // another press follows directly, skipping IDLE
          rep_nxt = rep_cnt - 4'd1;
          if (bnum == 4'd0) begin
            state_nxt = S_HOLD;
            cnt_nxt   = hold_load(hold_lat);
          end else begin
            state_nxt = S_PB;
            cnt_nxt   = BOUNCE_LOAD;
            half_nxt  = 1'b0;
            gcnt_nxt  = bnum;
          end
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode: key level per phase, final settle cycle, press count trigger.
  always_comb begin
    key_s = 1'b1;
    case (state)
      S_PB:    key_s = half;    // low half first, then high
      S_HOLD:  key_s = 1'b0;
      S_RB:    key_s = ~half;   // high half first, then low
      default: key_s = 1'b1;
    endcase
`ifdef KEY_GEN_REPEAT_EN
    settle_last_s = (state == S_SETTLE) && (cnt == {CW{1'b0}}) && (rep_cnt == 4'd0);
`else
    settle_last_s = (state == S_SETTLE) && (cnt == {CW{1'b0}});
`endif
    press_inc_s = (state_nxt == S_HOLD) && (state != S_HOLD);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_out   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      press_cnt <= 8'd0;
    end else begin
      key_out <= key_s;
      busy    <= (state != S_IDLE);
      done    <= settle_last_s;
      if (press_inc_s) begin
        press_cnt <= press_cnt + 8'd1;
      end else begin
        press_cnt <= press_cnt;
      end
    end
  end

endmodule
